// File: rtl/multiword_add_sequencer_if.sv
// Handshake bundle for the multiword add sequencer: operand-in and result-out
// channels plus the busy status.
`timescale 1ns/1ps
interface multiword_add_sequencer_if #(
  parameter int W     = 32,
  parameter int WORDS = 4
) ();
  localparam int WW = W * WORDS;

  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_a;
  logic [WW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          busy;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Iterative WORDS*W-bit adder/subtractor: one W-bit slice per cycle, LSB first,
// carry chained between slices; result, carry-out and signed overflow on a handshake.
`timescale 1ns/1ps
module multiword_add_sequencer #(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);
  localparam int WW = W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [WW-1:0]   a_r;
  logic [WW-1:0]   b_r;
  logic [WW-1:0]   sum_r;
  logic            cout_r;
  logic            ovf_r;
  logic            valid_r;

  logic [W-1:0]    a_slice_s;
  logic [W-1:0]    b_slice_s;
  logic [W:0]      slice_s;
  logic            last_s;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Chunk adder datapath; b_r already holds ~B for subtraction, carry_r the +1.
  assign a_slice_s = a_r[int'(idx_r) * W +: W];
  assign b_slice_s = b_r[int'(idx_r) * W +: W];
  assign slice_s   = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{W{1'b0}}, carry_r};
  assign last_s    = (idx_r == LAST_IDX);

  // in_ready and busy are forced low while reset is asserted, not only after the edge.
  assign bus.in_ready  = rst_n && (state_r == ST_IDLE);
  assign bus.busy      = rst_n && (state_r != ST_IDLE);
  assign bus.out_valid = valid_r;
  assign bus.out_sum   = sum_r;
  assign bus.out_cout  = cout_r;
  assign bus.out_ovf   = ovf_r;

  // Control FSM plus operand capture and in-place slice writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {WW{1'b0}};
      b_r     <= {WW{1'b0}};
      sum_r   <= {WW{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.in_a;
            b_r     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_r <= bus.in_sub;
            idx_r   <= {IW{1'b0}};
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[int'(idx_r) * W +: W] <= slice_s[W-1:0];
          carry_r <= slice_s[W];
          if (last_s) begin
            idx_r   <= {IW{1'b0}};
            cout_r  <= slice_s[W];
            ovf_r   <= ovf_f(a_r[WW-1], b_r[WW-1], slice_s[W-1]);
            valid_r <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_DONE: begin
          // Results stay frozen until the consumer takes them.
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          idx_r   <= {IW{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: directed vector table,
// multi-cycle corner sequences, and randomized streaming against a reference model.
`timescale 1ns/1ps
module tb_multiword_add_sequencer;
  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int WW    = W * WORDS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiword_add_sequencer_if #(.W(W), .WORDS(WORDS)) bus ();
  multiword_add_sequencer #(.W(W), .WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic          sub;
    logic [WW-1:0] sum;
    logic          cout;
    logic          ovf;
  } vec_t;

  typedef struct {
    logic [WW-1:0] sum;
    logic          cout;
    logic          ovf;
  } res_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-width arithmetic on sign-extended / zero-extended values.
  task automatic ref_model(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic sub,
                           output res_t r);
    logic signed [WW:0] sa, sb, sr;
    logic [WW:0] u;
    sa = $signed({a[WW-1], a});
    sb = $signed({b[WW-1], b});
    sr = sub ? (sa - sb) : (sa + sb);
    u  = {1'b0, a} + {1'b0, b};
    r.sum  = sub ? (a - b) : (a + b);
    r.cout = sub ? (a >= b) : u[WW];
    r.ovf  = sr[WW] ^ sr[WW-1];
  endtask

  function automatic logic [WW-1:0] rnd();
    logic [WW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {WW{1'b1}};
      1:       v = {1'b0, {(WW-1){1'b1}}};
      2:       v = {1'b1, {(WW-1){1'b0}}};
      default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Present one operand set, wait for the result and check the latency.
  task automatic run_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic sub,
                        input string name, output res_t r);
    int guard;
    int lat;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({name, "_in_ready"}, WW'(bus.in_ready), WW'(1));
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sub = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, WW'(lat), WW'(4));
    r.sum  = bus.out_sum;
    r.cout = bus.out_cout;
    r.ovf  = bus.out_ovf;
  endtask

  task automatic release_op(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_valid_drop"}, WW'(bus.out_valid), WW'(0));
    chk({name, "_idle_busy"}, WW'(bus.busy), WW'(0));
    chk({name, "_idle_ready"}, WW'(bus.in_ready), WW'(1));
  endtask

  vec_t vecs[7];
  res_t r, e, held;
  res_t expq[$];

  initial begin
    vecs[0] = '{{WW{1'b1}}, {{(WW-1){1'b0}}, 1'b1}, 1'b0, {WW{1'b0}}, 1'b1, 1'b0};
    vecs[1] = '{{1'b0, {(WW-1){1'b1}}}, {{(WW-1){1'b0}}, 1'b1}, 1'b0,
                {1'b1, {(WW-1){1'b0}}}, 1'b0, 1'b1};
    vecs[2] = '{128'd5, 128'd7, 1'b1, {{(WW-2){1'b1}}, 2'b10}, 1'b0, 1'b0};
    vecs[3] = '{{1'b1, {(WW-1){1'b0}}}, {{(WW-1){1'b0}}, 1'b1}, 1'b1,
                {1'b0, {(WW-1){1'b1}}}, 1'b1, 1'b1};
    vecs[4] = '{{WW{1'b0}}, {WW{1'b0}}, 1'b1, {WW{1'b0}}, 1'b1, 1'b0};
    vecs[5] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[6] = '{{1'b1, {(WW-1){1'b0}}}, {1'b1, {(WW-1){1'b0}}}, 1'b0,
                {WW{1'b0}}, 1'b1, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_a = {WW{1'b0}};
    bus.in_b = {WW{1'b0}};
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", WW'(bus.out_valid), WW'(0));
    chk("rst_in_ready", WW'(bus.in_ready), WW'(0));
    chk("rst_busy", WW'(bus.busy), WW'(0));
    chk("rst_out_sum", bus.out_sum, {WW{1'b0}});
    chk("rst_cout", WW'(bus.out_cout), WW'(0));
    chk("rst_ovf", WW'(bus.out_ovf), WW'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", WW'(bus.in_ready), WW'(1));

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i), r);
      chk($sformatf("vec%0d_sum", i), r.sum, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), WW'(r.cout), WW'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), WW'(r.ovf), WW'(vecs[i].ovf));
      release_op($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with new operands offered
    run_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
           1'b0, "bp", held);
    ref_model(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
              1'b0, e);
    chk("bp_sum", held.sum, e.sum);
    for (int i = 0; i < 10; i++) begin
      bus.in_a = rnd();
      bus.in_b = rnd();
      bus.in_sub = $urandom_range(0, 1) == 1;
      bus.in_valid = 1'b1;
      tick();
      chk("bp_hold_sum", bus.out_sum, held.sum);
      chk("bp_hold_flags", WW'({bus.out_cout, bus.out_ovf}), WW'({held.cout, held.ovf}));
      chk("bp_hold_valid", WW'(bus.out_valid), WW'(1));
      chk("bp_in_ready", WW'(bus.in_ready), WW'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", WW'(bus.out_valid), WW'(0));
    chk("bp_no_accept", WW'(bus.busy), WW'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset during RUN
    bus.in_a = 128'd100;
    bus.in_b = 128'd200;
    bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", WW'(bus.out_valid), WW'(0));
    chk("midrst_in_ready", WW'(bus.in_ready), WW'(0));
    chk("midrst_busy", WW'(bus.busy), WW'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_result", WW'(bus.out_valid), WW'(0));
    end
    run_op(128'd3, 128'd4, 1'b0, "postrst", r);
    chk("postrst_sum", r.sum, 128'd7);
    release_op("postrst");

    // Randomized streaming with both handshakes held open
    begin
      int cyc;
      int last_acc;
      int got;
      int acc_n;
      logic will_acc;
      cyc = 0;
      last_acc = -1;
      got = 0;
      acc_n = 0;
      bus.in_a = rnd();
      bus.in_b = rnd();
      bus.in_sub = $urandom_range(0, 1) == 1;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      while (got < 20 && cyc < 600) begin
        if (bus.out_valid) begin
          if (expq.size() == 0) begin
            chk("stream_unexpected_result", WW'(1), WW'(0));
          end else begin
            e = expq.pop_front();
            chk($sformatf("stream%0d_sum", got), bus.out_sum, e.sum);
            chk($sformatf("stream%0d_flags", got), WW'({bus.out_cout, bus.out_ovf}),
                WW'({e.cout, e.ovf}));
          end
          got++;
        end
        will_acc = bus.in_ready && bus.in_valid;
        if (will_acc) begin
          ref_model(bus.in_a, bus.in_b, bus.in_sub, e);
          expq.push_back(e);
          if (last_acc >= 0) chk("stream_spacing", WW'(cyc - last_acc), WW'(6));
          last_acc = cyc;
          acc_n++;
        end
        tick();
        cyc++;
        if (will_acc) begin
          bus.in_a = rnd();
          bus.in_b = rnd();
          bus.in_sub = $urandom_range(0, 1) == 1;
          if (acc_n >= 20) bus.in_valid = 1'b0;
        end
      end
      chk("stream_count", WW'(got), WW'(20));
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
